// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one result bit per clock, with a two-half-adder full-adder cell.
// Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN (adds port sub).

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sub_q, sub_d;
    logic              start_sub;

    logic              b_bit;
    logic              ha0_s, ha0_c;
    logic              ha1_s, ha1_c;
    logic              fa_s, fa_c;
    logic              last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign start_sub = sub;
`else
    assign start_sub = 1'b0;
`endif

    // In subtract mode B is inverted into the cell; carry starts at 1 to complete two's complement.
    assign b_bit = b_sh_q[0] ^ sub_q;

    half_adder u_ha0 (
        .a_i (a_sh_q[0]),
        .b_i (b_bit),
        .s_o (ha0_s),
        .c_o (ha0_c)
    );

    half_adder u_ha1 (
        .a_i (ha0_s),
        .b_i (carry_q),
        .s_o (ha1_s),
        .c_o (ha1_c)
    );

    assign fa_s     = ha1_s;
    assign fa_c     = ha0_c | ha1_c;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sub_d   = start_sub;
                    carry_d = start_sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Result enters at the MSB so bit 0 lands in sum[0] after WIDTH shifts.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=16): stimulus pushes expected results, a monitor
// pops and checks them on every done pulse, including latency and busy duration.

module tb_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c;
        int               done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   dones;
    int   busy_run;

    serial_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", longint'(sum), longint'(e.sum));
                    check("carry_out", longint'(carry_out), longint'(e.c));
                    check("latency", longint'(cyc), longint'(e.done_cyc));
                    check("busy_cycles", longint'(busy_run), 64'd16);
                end
                busy_run = 0;
            end
        end
    end

    // Pulse start for one accepting edge and queue the expected result.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv,
                         input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        a     = av;
        b     = bv;
        sub   = sv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        e.sum      = es;
        e.c        = ec;
        e.done_cyc = cyc + 16;
        exp_q.push_back(e);
    endtask

    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (dones < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (dones < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", dones, target);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   base;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        dones    = 0;
        busy_run = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;

        // Reset state, with start held high to show it is not accepted under reset.
        #12;
        start = 1'b1;
        a     = 16'h0009;
        b     = 16'h0009;
        @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 64'd0);
        check("rst_done", longint'(done), 64'd0);
        check("rst_sum", longint'(sum), 64'd0);
        check("rst_carry", longint'(carry_out), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", longint'(busy), 64'd0);

        // Basic add, then a restart attempt mid-RUN that must be ignored.
        issue(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0);
        check("busy_after_accept", longint'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        a     = 16'h0001;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_dones(1);
        repeat (20) @(posedge clk);
        #1;
        check("single_done", longint'(dones), 64'd1);

        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        wait_dones(2);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        wait_dones(3);
        issue(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0);
        wait_dones(4);
        check("sum_holds", longint'(sum), 64'hFFFF);

        // Reset at cycle 8 of RUN aborts without a done pulse.
        a     = 16'h0003;
        b     = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("busy_before_abort", longint'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", longint'(busy), 64'd0);
        check("abort_sum", longint'(sum), 64'd0);
        check("abort_carry", longint'(carry_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("no_done_after_abort", longint'(dones), 64'd4);
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        wait_dones(5);

        // Start held high over two operations: second accept 18 edges after the first.
        a     = 16'h00FF;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        base       = cyc;
        e.sum      = 16'h0100;
        e.c        = 1'b0;
        e.done_cyc = base + 16;
        exp_q.push_back(e);
        a          = 16'h8000;
        b          = 16'h8000;
        e.sum      = 16'h0000;
        e.c        = 1'b1;
        e.done_cyc = base + 34;
        exp_q.push_back(e);
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        wait_dones(7);

`ifdef SERIAL_ADDER_SUB_EN
        issue(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1);
        wait_dones(8);
        issue(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0);
        wait_dones(9);
`endif

        repeat (3) @(posedge clk);
        check("queue_drained", longint'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A, captured on the edge that accepts start.
REQ-006 SHALL have port: b  input  WIDTH  operand B, captured on the edge that accepts start.
REQ-007 SHALL have port: busy  output  1  high while an addition is in progress (RUN state).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: sum  output  WIDTH  result register.
REQ-010 SHALL have port: carry_out  output  1  carry out of the MSB.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge, load a and b into shift registers, clear carry, clear the bit counter and go to RUN.
REQ-013 SHALL, in RUN at each edge, form one sum bit from a_sh[0], b_sh[0] and the carry flop, using a full-adder cell built from two half_adder instances plus an OR gate.
REQ-014 SHALL, in RUN at each edge, shift the sum bit into the sum register at its MSB, shift both operands right by one, update the carry flop and increment the counter.
REQ-015 SHALL process operands LSB first, so that after WIDTH RUN edges sum[0] holds bit 0 of the result.
REQ-016 SHALL move from RUN to DONE on the edge that processes bit WIDTH-1.
REQ-017 SHALL move from DONE to IDLE unconditionally on the next edge.
REQ-018 SHALL hold busy=1 exactly while in RUN, i.e. for WIDTH cycles.
REQ-019 SHALL hold done=1 exactly while in DONE, i.e. for 1 cycle.
REQ-020 SHALL set latency so that done is high in the cycle after WIDTH+1 rising edges, counted from and including the edge that accepted start.
REQ-021 SHALL compute the result modulo 2^WIDTH, with carry_out equal to bit WIDTH of a+b.
REQ-022 SHALL ignore start while in RUN or DONE: no restart, and operands are not re-captured.
REQ-023 SHALL keep sum and carry_out stable from DONE until the next accepted start; their values during RUN are partial and not checked.
REQ-024 SHALL allow back-to-back operation: start held high continuously is accepted in the IDLE cycle following each DONE.
REQ-025 SHALL size the bit counter to $clog2(WIDTH+1) bits, and the counter SHALL NOT wrap within one operation.

Reset
REQ-026 SHALL, when reset is asserted, immediately force state=IDLE, busy=0, done=0, sum=0, carry_out=0, and clear the counter and operand registers, independent of clk.
REQ-027 SHALL, when reset is asserted mid-RUN, abort the operation with no done pulse; the next operation requires a fresh start after reset deasserts.
REQ-028 SHALL NOT accept start on any edge at which reset is high.

Configuration
REQ-029 SHALL recognise macro SERIAL_ADDER_SUB_EN.
REQ-030 SHALL, when SERIAL_ADDER_SUB_EN is defined, add port sub (input, 1), captured with the operands; sub=1 SHALL invert B bits into the cell and initialise carry to 1, so sum=a-b mod 2^WIDTH and carry_out=1 means no borrow.
REQ-031 SHALL, when SERIAL_ADDER_SUB_EN is undefined, omit port sub and perform addition only, with carry initialised to 0.

Verification (WIDTH=16)
REQ-032 SHALL cover: a=3, b=5, start pulse -> busy for 16 cycles, done 17 edges later, sum=0x0008, carry_out=0.
REQ-033 SHALL cover: a=0xFFFF, b=0x0001 -> sum=0x0000, carry_out=1; a=0xFFFF, b=0xFFFF -> sum=0xFFFE, carry_out=1.
REQ-034 SHALL cover: start re-pulsed with a=1, b=1 at cycle 5 of a 3+5 operation -> ignored; result 0x0008, exactly one done pulse.
REQ-035 SHALL cover: reset asserted at cycle 8 of RUN -> busy=0, sum=0 immediately; no done; a following 0x1234+0x1111 yields 0x2345.
REQ-036 SHALL cover: start held high over two operations, 0x00FF+0x0001 then 0x8000+0x8000 -> done pulses 18 edges apart, results 0x0100/c=0 and 0x0000/c=1.
REQ-037 SHALL cover, with SERIAL_ADDER_SUB_EN defined: a=5, b=3, sub=1 -> sum=0x0002, carry_out=1; a=3, b=5, sub=1 -> sum=0xFFFE, carry_out=0.
